// File: rtl/drone_pkg.sv
// Shared types and constants for the blob-centroid block.
//   X_W/Y_W        widths of pixel column/row coordinates
//   SUM_W/CNT_W    accumulator widths, sized for a full 640x480 frame
//   SCREEN_W/H     visible area; coordinates outside it are never accumulated
//   cent_state_t   centroid FSM states
//   smooth_step    (3*old + new) >> 2 on a 12-bit intermediate
package drone_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int SUM_W    = 28;
  localparam int CNT_W    = 19;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    DIV_X   = 3'd2,
    DIV_Y   = 3'd3,
    PUBLISH = 3'd4
  } cent_state_t;

  // 3*639 + 639 = 2556, so 12 bits never wrap.
  function automatic logic [11:0] smooth_step(input logic [11:0] old_v,
                                              input logic [11:0] new_v);
    logic [11:0] acc;
    acc = (old_v << 1) + old_v + new_v;
    return acc >> 2;
  endfunction

endpackage

// File: rtl/seq_div.sv
// Fixed-latency restoring divider, one quotient bit per cycle.
//   vga_clk, reset : clock, asynchronous active-high reset
//   start          : one-cycle pulse; loads dividend and performs the first step
//   dividend       : SUM_W-bit numerator, sampled only on start
//   divisor        : CNT_W-bit denominator, must stay stable until done
//   done           : high for the cycle in which quotient is final
//   quotient       : low X_W bits of the truncated quotient
// Start plus 27 further steps gives 28 quotient bits; done rises 28 cycles
// after the start cycle. A start while done is high restarts immediately,
// which lets the caller chain X then Y back to back.
module seq_div
  import drone_pkg::*;
(
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [X_W-1:0]   quotient
);

  localparam logic [4:0] REMAINING_STEPS = 5'(SUM_W - 1);

  logic [CNT_W-1:0] rem;
  logic [SUM_W-1:0] quo;
  logic [4:0]       steps;
  logic             running;

  logic [CNT_W-1:0] rem_in;
  logic [SUM_W-1:0] quo_in;
  logic [CNT_W:0]   shifted;
  logic [CNT_W:0]   diff;
  logic             fits;
  logic [CNT_W-1:0] rem_out;
  logic [SUM_W-1:0] quo_out;

  // One restoring step. The partial remainder is always < divisor, so the
  // shifted value is < 2*divisor and the result fits back into CNT_W bits.
  always_comb begin
    rem_in  = start ? '0 : rem;
    quo_in  = start ? dividend : quo;
    shifted = {rem_in, quo_in[SUM_W-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = (shifted >= {1'b0, divisor});
    rem_out = fits ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    quo_out = {quo_in[SUM_W-2:0], fits};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rem     <= '0;
      quo     <= '0;
      steps   <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= rem_out;
      quo     <= quo_out;
      steps   <= REMAINING_STEPS;
      running <= 1'b1;
    end else if (running) begin
      if (steps != 5'd0) begin
        rem   <= rem_out;
        quo   <= quo_out;
        steps <= steps - 5'd1;
      end else begin
        running <= 1'b0;
      end
    end
  end

  assign done     = running && (steps == 5'd0);
  assign quotient = quo[X_W-1:0];

endmodule

// File: rtl/blob_centroid.sv
// Per-frame centroid of binarised "on" pixels.
//   vga_clk, reset : 25 MHz pixel clock, asynchronous active-high reset
//   img            : visible-area qualifier
//   vsync          : vertical sync; the active transition marks frame end
//   pos_x, pos_y   : current pixel coordinates
//   pix_on         : binarised pixel
//   cx, cy         : centroid of the last target frame, held between updates
//   pix_count      : on-pixel count of the last completed frame
//   target         : last frame had at least MIN_COUNT on-pixels
//   cent_valid     : one-cycle pulse when the outputs above update
//   busy           : FSM not idle (frame-end capture until publish)
//   overrun        : sticky, frame end seen while busy; cleared by reset only
//   state_dbg      : current FSM state
// Build option: define CENTROID_SMOOTH_EN to low-pass cx/cy across
// consecutive target frames; latency is the same either way.
// Handshake: cent_valid is a pure strobe with no ready; the consumer must
// sample cx/cy/pix_count/target in the cycle it is high (or any time after,
// since they hold until the next pulse).
module blob_centroid
  import drone_pkg::*;
#(
  parameter int MIN_COUNT     = 64,
  parameter int VSYNC_ACT_LOW = 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             img,
  input  logic             vsync,
  input  logic [X_W-1:0]   pos_x,
  input  logic [Y_W-1:0]   pos_y,
  input  logic             pix_on,
  output logic [X_W-1:0]   cx,
  output logic [Y_W-1:0]   cy,
  output logic [CNT_W-1:0] pix_count,
  output logic             target,
  output logic             cent_valid,
  output logic             busy,
  output logic             overrun,
  output cent_state_t      state_dbg
);

  localparam logic VSYNC_IDLE_LVL = 1'(VSYNC_ACT_LOW != 0);

  cent_state_t      state;
  logic             vsync_q;
  logic [SUM_W-1:0] sum_x, sum_y, snap_sum_x, snap_sum_y;
  logic [CNT_W-1:0] cnt, snap_cnt;
  logic [X_W-1:0]   cx_next;
  logic [Y_W-1:0]   cy_next;

  logic             frame_edge;
  logic             qualify;
  logic             snap_target;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [X_W-1:0]   div_quo;

  assign frame_edge  = VSYNC_ACT_LOW != 0 ? (vsync_q & ~vsync) : (~vsync_q & vsync);
  assign qualify     = img && pix_on &&
                       (32'(pos_x) < SCREEN_W) && (32'(pos_y) < SCREEN_H);
  assign snap_target = (snap_cnt >= CNT_W'(MIN_COUNT));

  // X is started from CHECK, Y is started in the cycle X completes.
  assign div_start    = ((state == CHECK) && snap_target) ||
                        ((state == DIV_X) && div_done);
  assign div_dividend = (state == DIV_X) ? snap_sum_y : snap_sum_x;

  seq_div u_div (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_cnt),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Accumulators and snapshot. The frame-end cycle always clears the live
  // sums (dropping any pixel in that cycle); the snapshot is only refreshed
  // when no division is using it.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vsync_q    <= VSYNC_IDLE_LVL;
      sum_x      <= '0;
      sum_y      <= '0;
      cnt        <= '0;
      snap_sum_x <= '0;
      snap_sum_y <= '0;
      snap_cnt   <= '0;
      overrun    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (frame_edge) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
        if (state == IDLE) begin
          snap_sum_x <= sum_x;
          snap_sum_y <= sum_y;
          snap_cnt   <= cnt;
        end else begin
          overrun <= 1'b1;
        end
      end else if (qualify) begin
        sum_x <= sum_x + SUM_W'(pos_x);
        sum_y <= sum_y + SUM_W'(pos_y);
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cx_next    <= '0;
      cy_next    <= '0;
      cx         <= '0;
      cy         <= '0;
      pix_count  <= '0;
      target     <= 1'b0;
      cent_valid <= 1'b0;
    end else begin
      cent_valid <= 1'b0;
      case (state)
        IDLE:    if (frame_edge) state <= CHECK;
        CHECK:   state <= snap_target ? DIV_X : PUBLISH;
        DIV_X: begin
          if (div_done) begin
            cx_next <= div_quo;
            state   <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            cy_next <= div_quo[Y_W-1:0];
            state   <= PUBLISH;
          end
        end
        PUBLISH: begin
          pix_count  <= snap_cnt;
          target     <= snap_target;
          cent_valid <= 1'b1;
          state      <= IDLE;
          if (snap_target) begin
`ifdef CENTROID_SMOOTH_EN
            // target still holds the previous frame's flag here.
            if (target) begin
              cx <= X_W'(smooth_step(12'(cx), 12'(cx_next)));
              cy <= Y_W'(smooth_step(12'(cy), 12'(cy_next)));
            end else begin
              cx <= cx_next;
              cy <= cy_next;
            end
`else
            cx <= cx_next;
            cy <= cy_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_blob_centroid.sv
module tb_blob_centroid;
  import drone_pkg::*;

`ifdef CENTROID_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  // clock / reset
  logic vga_clk = 1'b0;
  logic reset, img, vsync, pix_on;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [18:0] pix_count;
  logic        target, cent_valid, busy, overrun;
  cent_state_t state_dbg;

  always #20 vga_clk = ~vga_clk;

  blob_centroid dut (
    .vga_clk(vga_clk), .reset(reset), .img(img), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .pix_on(pix_on),
    .cx(cx), .cy(cy), .pix_count(pix_count), .target(target),
    .cent_valid(cent_valid), .busy(busy), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // reference model of the published centroid
  int m_cx = 0, m_cy = 0, m_tgt = 0;
  // scoreboard of expected published results, packed as {cx, cy, count}
  logic [37:0] exp_q[$];

  task automatic model_publish(input int rx, input int ry, input int cnt);
    if (cnt >= 64) begin
      if (SMOOTH && m_tgt != 0) begin
        m_cx = (3 * m_cx + rx) >> 2;
        m_cy = (3 * m_cy + ry) >> 2;
      end else begin
        m_cx = rx;
        m_cy = ry;
      end
      m_tgt = 1;
    end else begin
      m_tgt = 0;
    end
    exp_q.push_back({10'(m_cx), 9'(m_cy), 19'(cnt)});
  endtask

  // driver tasks
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge vga_clk); #1;
      img = 1'b0; pix_on = 1'b0;
    end
  endtask

  task automatic feed_rect(input int x0, input int y0, input int w, input int h);
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = x0; x < x0 + w; x++) begin
        @(posedge vga_clk); #1;
        img = 1'b1; pix_on = 1'b1; pos_x = 10'(x); pos_y = 9'(y);
      end
    end
    @(posedge vga_clk); #1;
    img = 1'b0; pix_on = 1'b0;
  endtask

  // pixels that must never be counted
  task automatic feed_noise();
    logic [27:0] vec [6];
    vec[0] = {1'b1, 1'b0, 10'd100, 9'd50, 7'd0};
    vec[1] = {1'b0, 1'b1, 10'd100, 9'd50, 7'd0};
    vec[2] = {1'b1, 1'b1, 10'd640, 9'd0,  7'd0};
    vec[3] = {1'b1, 1'b1, 10'd1023, 9'd100, 7'd0};
    vec[4] = {1'b1, 1'b1, 10'd5,   9'd480, 7'd0};
    vec[5] = {1'b1, 1'b1, 10'd5,   9'd511, 7'd0};
    for (int i = 0; i < 6; i++) begin
      @(posedge vga_clk); #1;
      img = vec[i][27]; pix_on = vec[i][26];
      pos_x = vec[i][25:16]; pos_y = vec[i][15:7];
    end
    @(posedge vga_clk); #1;
    img = 1'b0; pix_on = 1'b0;
  endtask

  // Drives a frame end (cycle E) and waits for cent_valid; lat is the n of
  // cycle E+n where it was seen, -1 on timeout.
  task automatic frame_end(input int max, output int lat, output logic busy1,
                           output cent_state_t st1);
    @(posedge vga_clk); #1;
    vsync = 1'b0; img = 1'b0; pix_on = 1'b0;
    lat = -1; busy1 = 1'b0; st1 = IDLE;
    for (int n = 1; n <= max; n++) begin
      @(posedge vga_clk); #1;
      vsync = 1'b1;
      @(negedge vga_clk);
      if (n == 1) begin busy1 = busy; st1 = state_dbg; end
      if (cent_valid) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; img = 1'b0; pix_on = 1'b0; pos_x = '0; pos_y = '0;
    repeat (3) @(posedge vga_clk);
    #1 reset = 1'b0;
    @(negedge vga_clk);
    total++; if ({cx, cy, pix_count, target, cent_valid, busy, overrun} !== '0) begin
      bad++; $display("FAIL reset_outputs got cx=%0d cy=%0d cnt=%0d tgt=%0b v=%0b busy=%0b ovr=%0b exp all 0",
                      cx, cy, pix_count, target, cent_valid, busy, overrun); end
    total++; if (state_dbg !== IDLE) begin
      bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
  endtask

  task automatic test_square();
    int lat; logic b1; cent_state_t s1; logic [37:0] e;
    feed_noise();
    feed_rect(100, 50, 8, 8);
    feed_noise();
    model_publish(103, 53, 64);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 59) begin bad++; $display("FAIL sq_latency got=%0d exp=59", lat); end
    total++; if (b1 !== 1'b1 || s1 !== CHECK) begin
      bad++; $display("FAIL sq_check_state got busy=%0b st=%0d exp busy=1 st=%0d", b1, s1, CHECK); end
    total++; if ({cx, cy, pix_count} !== e) begin
      bad++; $display("FAIL sq_result got cx=%0d cy=%0d cnt=%0d exp cx=%0d cy=%0d cnt=%0d",
                      cx, cy, pix_count, e[37:28], e[27:19], e[18:0]); end
    total++; if (target !== 1'b1) begin bad++; $display("FAIL sq_target got=%0b exp=1", target); end
    @(negedge vga_clk);
    total++; if (cent_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sq_pulse_width got v=%0b busy=%0b exp 0 0", cent_valid, busy); end
  endtask

  task automatic test_small();
    int lat; logic b1; cent_state_t s1; logic [37:0] e;
    feed_rect(300, 300, 10, 1);
    model_publish(0, 0, 10);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 3) begin bad++; $display("FAIL small_latency got=%0d exp=3", lat); end
    total++; if ({cx, cy, pix_count, target} !== {e, 1'b0}) begin
      bad++; $display("FAIL small_result got cx=%0d cy=%0d cnt=%0d tgt=%0b exp cx=%0d cy=%0d cnt=%0d tgt=0",
                      cx, cy, pix_count, target, e[37:28], e[27:19], e[18:0]); end
  endtask

  // Symmetric cover of the full screen: every column on rows 0, 159, 320, 479.
  task automatic test_full_span();
    int lat; logic b1; cent_state_t s1; logic [37:0] e;
    feed_rect(0, 0, 640, 1);
    feed_rect(0, 159, 640, 1);
    feed_noise();
    feed_rect(0, 320, 640, 1);
    feed_rect(0, 479, 640, 1);
    model_publish(319, 239, 2560);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 59) begin bad++; $display("FAIL full_latency got=%0d exp=59", lat); end
    total++; if ({cx, cy, pix_count} !== e || target !== 1'b1) begin
      bad++; $display("FAIL full_result got cx=%0d cy=%0d cnt=%0d tgt=%0b exp cx=%0d cy=%0d cnt=%0d tgt=1",
                      cx, cy, pix_count, target, e[37:28], e[27:19], e[18:0]); end
  endtask

  task automatic test_overrun();
    int lat; logic b1; cent_state_t s1; logic [37:0] e;
    feed_rect(200, 100, 8, 8);
    model_publish(203, 103, 64);
    @(posedge vga_clk); #1;
    vsync = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge vga_clk); #1;
      vsync  = (n == 20) ? 1'b0 : 1'b1;
      img    = (n >= 2 && n <= 15);
      pix_on = img; pos_x = 10'd600; pos_y = 9'd400;
      @(negedge vga_clk);
      if (n == 21) begin
        total++; if (overrun !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL ovr_flag got ovr=%0b busy=%0b exp 1 1", overrun, busy); end
      end
      if (cent_valid) begin lat = n; break; end
    end
    e = exp_q.pop_front();
    total++; if (lat !== 59) begin bad++; $display("FAIL ovr_latency got=%0d exp=59", lat); end
    total++; if ({cx, cy, pix_count} !== e) begin
      bad++; $display("FAIL ovr_first got cx=%0d cy=%0d cnt=%0d exp cx=%0d cy=%0d cnt=%0d",
                      cx, cy, pix_count, e[37:28], e[27:19], e[18:0]); end
    idle_cycles(4);
    feed_rect(300, 200, 8, 8);
    model_publish(303, 203, 64);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 59 || {cx, cy, pix_count} !== e) begin
      bad++; $display("FAIL ovr_next got lat=%0d cx=%0d cy=%0d cnt=%0d exp lat=59 cx=%0d cy=%0d cnt=%0d",
                      lat, cx, cy, pix_count, e[37:28], e[27:19], e[18:0]); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
  endtask

  task automatic test_reset_mid_div();
    int lat; logic b1; cent_state_t s1; logic [37:0] e;
    feed_rect(400, 300, 8, 8);
    @(posedge vga_clk); #1;
    vsync = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge vga_clk); #1;
      vsync = 1'b1;
    end
    @(negedge vga_clk);
    total++; if (state_dbg !== DIV_Y) begin
      bad++; $display("FAIL mid_state got=%0d exp=%0d", state_dbg, DIV_Y); end
    @(posedge vga_clk); #1;
    reset = 1'b1;
    @(negedge vga_clk);
    total++; if ({cx, cy, pix_count, target, cent_valid, busy, overrun} !== '0 || state_dbg !== IDLE) begin
      bad++; $display("FAIL mid_reset got cx=%0d cy=%0d cnt=%0d tgt=%0b v=%0b busy=%0b ovr=%0b st=%0d exp all 0",
                      cx, cy, pix_count, target, cent_valid, busy, overrun, state_dbg); end
    @(posedge vga_clk); #1;
    reset = 1'b0;
    m_cx = 0; m_cy = 0; m_tgt = 0;
    feed_rect(10, 20, 8, 8);
    model_publish(13, 23, 64);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 59 || {cx, cy, pix_count} !== e || target !== 1'b1) begin
      bad++; $display("FAIL mid_after got lat=%0d cx=%0d cy=%0d cnt=%0d tgt=%0b exp lat=59 cx=%0d cy=%0d cnt=%0d tgt=1",
                      lat, cx, cy, pix_count, target, e[37:28], e[27:19], e[18:0]); end
  endtask

  // 63 pixels (one short of MIN_COUNT), then two consecutive target frames.
  task automatic test_back_to_back();
    int lat; logic b1; cent_state_t s1; logic [37:0] e;
    int exp_cx2, exp_cy2;
    feed_rect(0, 0, 63, 1);
    model_publish(0, 0, 63);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 3 || target !== 1'b0 || {cx, cy, pix_count} !== e) begin
      bad++; $display("FAIL b2b_min got lat=%0d tgt=%0b cx=%0d cy=%0d cnt=%0d exp lat=3 tgt=0 cx=%0d cy=%0d cnt=%0d",
                      lat, target, cx, cy, pix_count, e[37:28], e[27:19], e[18:0]); end
    feed_rect(96, 46, 9, 9);
    model_publish(100, 50, 81);
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 59 || {cx, cy, pix_count} !== e) begin
      bad++; $display("FAIL b2b_f1 got lat=%0d cx=%0d cy=%0d cnt=%0d exp lat=59 cx=%0d cy=%0d cnt=%0d",
                      lat, cx, cy, pix_count, e[37:28], e[27:19], e[18:0]); end
    feed_rect(196, 146, 9, 9);
    model_publish(200, 150, 81);
    exp_cx2 = SMOOTH ? 125 : 200;
    exp_cy2 = SMOOTH ? 75 : 150;
    frame_end(100, lat, b1, s1);
    e = exp_q.pop_front();
    total++; if (lat !== 59 || {cx, cy, pix_count} !== e) begin
      bad++; $display("FAIL b2b_f2 got lat=%0d cx=%0d cy=%0d cnt=%0d exp lat=59 cx=%0d cy=%0d cnt=%0d",
                      lat, cx, cy, pix_count, e[37:28], e[27:19], e[18:0]); end
    total++; if (cx !== 10'(exp_cx2) || cy !== 9'(exp_cy2)) begin
      bad++; $display("FAIL b2b_f2_const got cx=%0d cy=%0d exp cx=%0d cy=%0d", cx, cy, exp_cx2, exp_cy2); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_square();
    test_small();
    test_full_span();
    test_overrun();
    test_reset_mid_div();
    test_back_to_back();
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
